// File: rtl/uart_report_arb.sv
// Round-robin arbiter that frames finger-count and frame-time results into
// header/type/payload/checksum packets for a single UART byte transmitter.
module uart_report_arb #(
    parameter logic [7:0] HDR       = 8'hA5,
    parameter logic [7:0] TYPE_FING = 8'h01,
    parameter logic [7:0] TYPE_TIME = 8'h02
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fing_req,
    input  logic [3:0]  fing_num,
    input  logic        time_req,
    input  logic [31:0] time_val,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_pend_f, r_pend_t, r_last_time;
    logic        r_tx_valid;
    logic [7:0]  r_tx_data, r_drop_cnt;
    logic [2:0]  r_idx;
    logic        r_kind;
    logic [31:0] r_snap;
    logic [7:0]  r_chk;
    logic [3:0]  r_fing;
    logic [31:0] r_time;

    logic w_grant, w_grant_time, w_xfer, w_last;
    logic w_fcap, w_tcap, w_drop_f, w_drop_t;
    logic [7:0] w_chk_f, w_chk_t;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, inc};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // kind=1 selects the 7-byte frame-time layout; fing payload sits zero-extended in snap.
    function automatic logic [7:0] byte_at(input logic kind, input logic [2:0] idx,
                                           input logic [31:0] snap, input logic [7:0] chk);
        case (idx)
            3'd0:    return HDR;
            3'd1:    return kind ? TYPE_TIME : TYPE_FING;
            3'd2:    return kind ? snap[31:24] : {4'h0, snap[3:0]};
            3'd3:    return kind ? snap[23:16] : chk;
            3'd4:    return snap[15:8];
            3'd5:    return snap[7:0];
            3'd6:    return chk;
            default: return 8'h00;
        endcase
    endfunction

    assign w_fcap  = fing_req & enable;
    assign w_tcap  = time_req & enable;
    assign w_chk_f = TYPE_FING ^ {4'h0, r_fing};
    assign w_chk_t = TYPE_TIME ^ r_time[31:24] ^ r_time[23:16] ^ r_time[15:8] ^ r_time[7:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_grant_time = 1'b0;
        w_xfer       = r_tx_valid & tx_ready;
        w_last       = (r_idx == (r_kind ? 3'd6 : 3'd3));
        case (r_state)
            S_IDLE: begin
                if (r_pend_f | r_pend_t) begin
                    w_grant      = 1'b1;
                    w_grant_time = r_pend_t & (~r_pend_f | ~r_last_time);
                    w_state_nxt  = S_SEND;
                end
            end
            S_SEND: begin
                if (w_xfer && w_last)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A request for the source being granted this cycle refills pending without a drop.
    assign w_drop_f = w_fcap & r_pend_f & ~(w_grant & ~w_grant_time);
    assign w_drop_t = w_tcap & r_pend_t & ~(w_grant & w_grant_time);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_f    <= 1'b0;
            r_pend_t    <= 1'b0;
            r_last_time <= 1'b1;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_drop_cnt  <= 8'h00;
            r_idx       <= 3'd0;
        end else begin
            if (w_fcap)
                r_pend_f <= 1'b1;
            else if (w_grant && !w_grant_time)
                r_pend_f <= 1'b0;
            if (w_tcap)
                r_pend_t <= 1'b1;
            else if (w_grant && w_grant_time)
                r_pend_t <= 1'b0;
            r_drop_cnt <= sat_add(r_drop_cnt, {1'b0, w_drop_f} + {1'b0, w_drop_t});

            if (w_grant) begin
                r_last_time <= w_grant_time;
                r_idx       <= 3'd0;
                r_tx_valid  <= 1'b1;
                r_tx_data   <= HDR;
            end else if (r_state == S_SEND && w_xfer) begin
                if (w_last) begin
                    r_tx_valid <= 1'b0;
                end else begin
                    r_idx     <= r_idx + 3'd1;
                    r_tx_data <= byte_at(r_kind, r_idx + 3'd1, r_snap, r_chk);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fcap)
            r_fing <= fing_num;
        if (w_tcap)
            r_time <= time_val;
        if (w_grant) begin
            r_kind <= w_grant_time;
            r_snap <= w_grant_time ? r_time : {28'h0, r_fing};
            r_chk  <= w_grant_time ? w_chk_t : w_chk_f;
        end
    end

    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign busy     = (r_state == S_SEND);
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_uart_report_arb.sv
// Directed bench for uart_report_arb: packet framing, stalls, round robin,
// overwrite counting with saturation, enable gating and mid-packet reset.
module tb_uart_report_arb;

    logic        clk = 1'b0;
    logic        rst, enable, fing_req, time_req, tx_ready;
    logic [3:0]  fing_num;
    logic [31:0] time_val;
    logic        tx_valid, busy;
    logic [7:0]  tx_data, drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    uart_report_arb dut (
        .clk(clk), .rst(rst), .enable(enable),
        .fing_req(fing_req), .fing_num(fing_num),
        .time_req(time_req), .time_val(time_val),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Advance one cycle; requests are one-cycle pulses.
    task automatic cyc();
        @(posedge clk);
        #1;
        fing_req = 1'b0;
        time_req = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // bytes packed MSB-first; checks n consecutive transfers, then the idle cycle if tail.
    task automatic expect_pkt(input string tag, input logic [55:0] bytes, input int n, input bit tail);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
            chk({tag, "_data"}, 32'(tx_data), 32'(bytes[55-8*i -: 8]));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            cyc();
        end
        if (tail) begin
            chk({tag, "_end_valid"}, 32'(tx_valid), 32'd0);
            chk({tag, "_end_busy"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; fing_req = 1'b0; time_req = 1'b0;
        tx_ready = 1'b1; fing_num = 4'h0; time_val = 32'h0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);

        // Finger packet, header two cycles after the request
        fing_req = 1'b1; fing_num = 4'd3;
        cyc();
        chk("fing_lat_valid", 32'(tx_valid), 32'd0);
        cyc();
        expect_pkt("fing3", {8'hA5, 8'h01, 8'h03, 8'h02, 24'h0}, 4, 1'b1);
        chk("fing3_drop", 32'(drop_cnt), 32'd0);

        // Frame-time packet
        time_req = 1'b1; time_val = 32'h0000_1234;
        cyc();
        chk("time_lat_valid", 32'(tx_valid), 32'd0);
        cyc();
        expect_pkt("time1234", {8'hA5, 8'h02, 8'h00, 8'h00, 8'h12, 8'h34, 8'h24}, 7, 1'b1);

        // Simultaneous requests after reset, then round robin
        rst = 1'b1; cyc(); rst = 1'b0;
        fing_req = 1'b1; fing_num = 4'd7;
        time_req = 1'b1; time_val = 32'hDEAD_BEEF;
        cyc(); cyc();
        fing_req = 1'b1; fing_num = 4'd9;
        expect_pkt("rr_fing7", {8'hA5, 8'h01, 8'h07, 8'h06, 24'h0}, 4, 1'b1);
        cyc();
        expect_pkt("rr_time", {8'hA5, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h20}, 7, 1'b1);
        cyc();
        expect_pkt("rr_fing9", {8'hA5, 8'h01, 8'h09, 8'h08, 24'h0}, 4, 1'b1);
        chk("rr_drop", 32'(drop_cnt), 32'd0);

        // Backpressure on byte 2 for five cycles
        time_req = 1'b1; time_val = 32'h0102_0304;
        cyc(); cyc();
        expect_pkt("stall_head", {8'hA5, 8'h02, 40'h0}, 2, 1'b0);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(tx_valid), 32'd1);
            chk("stall_data", 32'(tx_data), 32'h01);
            cyc();
        end
        tx_ready = 1'b1;
        expect_pkt("stall_tail", {8'h01, 8'h02, 8'h03, 8'h04, 8'h06, 16'h0}, 5, 1'b1);

        // Overwrite of a pending finger count during a time packet
        time_req = 1'b1; time_val = 32'h0;
        cyc(); cyc();
        chk("ow_hdr", 32'(tx_data), 32'hA5);
        fing_req = 1'b1; fing_num = 4'd2;
        cyc();
        chk("ow_type", 32'(tx_data), 32'h02);
        fing_req = 1'b1; fing_num = 4'd5;
        cyc();
        expect_pkt("ow_time", {8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 16'h0}, 5, 1'b1);
        chk("ow_drop1", 32'(drop_cnt), 32'd1);
        cyc();
        expect_pkt("ow_fing5", {8'hA5, 8'h01, 8'h05, 8'h04, 24'h0}, 4, 1'b1);
        chk("ow_drop1_after", 32'(drop_cnt), 32'd1);

        // Saturation while a packet is stalled at its header
        tx_ready = 1'b0;
        fing_req = 1'b1; fing_num = 4'd1;
        cyc(); cyc();
        chk("sat_hdr", 32'(tx_data), 32'hA5);
        fing_req = 1'b1; fing_num = 4'd2;
        cyc();
        fing_req = 1'b1; fing_num = 4'd3;
        cyc();
        chk("sat_drop2", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 256; i++) begin
            fing_req = 1'b1;
            cyc();
        end
        chk("sat_drop_ff", 32'(drop_cnt), 32'hFF);
        chk("sat_hold_valid", 32'(tx_valid), 32'd1);
        chk("sat_hold_data", 32'(tx_data), 32'hA5);

        // Reset in the middle of a packet
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mrst_valid", 32'(tx_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_drop", 32'(drop_cnt), 32'd0);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("mrst_quiet", 32'(tx_valid), 32'd0);
            cyc();
        end

        // Enable gating
        enable = 1'b0;
        fing_req = 1'b1; fing_num = 4'd4;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("en_off_quiet", 32'(tx_valid), 32'd0);
            cyc();
        end
        enable = 1'b1;
        time_req = 1'b1; time_val = 32'h00FF_00FF;
        cyc(); cyc();
        enable = 1'b0;
        fing_req = 1'b1; fing_num = 4'd6;
        expect_pkt("en_fall_time", {8'hA5, 8'h02, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h02}, 7, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("en_fall_quiet", 32'(tx_valid), 32'd0);
        end
        chk("en_fall_drop", 32'(drop_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
